// File: rtl/tremolo_modulator.sv
`default_nettype none
// ============================================================================
// Module   : tremolo_modulator
// Purpose  : LFO amplitude modulation of an audio stream using serial
//            shift-add arithmetic (no hard multipliers). One result is
//            produced 20 cycles after each accepted sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module tremolo_modulator #(
  parameter int DW = 16
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 sample_tick_i,
  input  logic signed [DW-1:0] sample_i,
  input  logic [8:0]           lfo_i,
  input  logic [7:0]           depth_i,
  output logic signed [DW-1:0] sample_o,
  output logic                 sample_valid_o,
  output logic                 busy_o,
  output logic                 ovr_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATT  = 3'd1;
  localparam logic [2:0] S_GAIN = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  localparam logic [3:0] ATT_LAST = 4'd7;
  localparam logic [3:0] MUL_LAST = 4'd9;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [3:0]           cnt;
  logic signed [DW-1:0] smp;
  logic [8:0]           inv;
  logic [7:0]           dep;
  logic [16:0]          att_acc;
  logic [9:0]           gain;
  logic signed [DW+9:0] prod;

  logic                 accept;
  logic                 computing;
  logic                 busy_nxt;
  logic                 valid_nxt;
  logic                 ovr_set;
  logic signed [DW+9:0] addend;
  logic signed [DW+9:0] prod_nxt;

  // A tick is only accepted when no computation is in flight.
  assign computing = (state == S_ATT) || (state == S_GAIN) || (state == S_MUL);
  assign accept    = sample_tick_i && ((state == S_IDLE) || (state == S_OUT));

  // State register; reset aborts any computation in progress.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: fixed 8 + 1 + 10 + 1 cycle schedule.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (sample_tick_i) state_nxt = S_ATT;
      S_ATT:   if (cnt == ATT_LAST) state_nxt = S_GAIN;
      S_GAIN:  state_nxt = S_MUL;
      S_MUL:   if (cnt == MUL_LAST) state_nxt = S_OUT;
      S_OUT:   state_nxt = sample_tick_i ? S_ATT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered status outputs and the
  // serial multiplier step for sample x gain (one gain bit per cycle).
  always_comb begin
    busy_nxt  = (state_nxt == S_ATT) || (state_nxt == S_GAIN) || (state_nxt == S_MUL);
    valid_nxt = (state_nxt == S_OUT);
    ovr_set   = sample_tick_i && computing;
    addend    = $signed({{10{smp[DW-1]}}, smp}) <<< cnt;
    prod_nxt  = gain[cnt] ? (prod + addend) : prod;
  end

  // Status outputs, all registered.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      busy_o         <= 1'b0;
      sample_valid_o <= 1'b0;
      ovr_o          <= 1'b0;
    end else begin
      busy_o         <= busy_nxt;
      sample_valid_o <= valid_nxt;
      if (ovr_set) begin
        ovr_o <= 1'b1;
      end
    end
  end

  // Operand capture and serial datapath; operands are frozen after accept.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt      <= '0;
      smp      <= '0;
      inv      <= '0;
      dep      <= '0;
      att_acc  <= '0;
      gain     <= '0;
      prod     <= '0;
      sample_o <= '0;
    end else begin
      case (state)
        S_IDLE, S_OUT: begin
          if (accept) begin
            smp     <= sample_i;
            inv     <= ~lfo_i;          // 511 - lfo
            dep     <= depth_i;
            att_acc <= '0;
            cnt     <= '0;
          end
        end
        S_ATT: begin
          if (dep[cnt[2:0]]) begin
            att_acc <= att_acc + ({8'd0, inv} << cnt);
          end
          cnt <= cnt + 4'd1;
        end
        S_GAIN: begin
          gain <= 10'd512 - {1'b0, att_acc[16:8]};
          prod <= '0;
          cnt  <= '0;
        end
        S_MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == MUL_LAST) begin
            sample_o <= prod_nxt[DW+8:9];
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
